// File: rtl/snake_step_ctrl.sv
// Snake game-logic controller: step FSM, collision/apple detection and per-pixel object query.
// Define SNAKE_WALL_WRAP_EN to remove the border walls and wrap the head around the grid.
module snake_step_ctrl #(
  parameter int STEP_CYCLES = 12_500_000,
  parameter int MAX_LEN     = 16,
  parameter int INIT_LEN    = 3
) (
  input  logic       Clk_25mhz,
  input  logic       Rst,
  input  logic       Start,
  input  logic       Key_up,
  input  logic       Key_down,
  input  logic       Key_left,
  input  logic       Key_right,
  input  logic [5:0] Apple_x,
  input  logic [4:0] Apple_y,
  input  logic [9:0] Pixel_x,
  input  logic [9:0] Pixel_y,
  output logic [1:0] Object,
  output logic       Apple_eaten,
  output logic       Game_over,
  output logic [4:0] Snake_len
);

`ifdef SNAKE_WALL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [1:0] OBJ_NONE = 2'b00;
  localparam logic [1:0] OBJ_HEAD = 2'b01;
  localparam logic [1:0] OBJ_BODY = 2'b10;
  localparam logic [1:0] OBJ_WALL = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHECK, S_MOVE, S_DEAD} state_t;
  // Bit 0 flips between opposite directions, so a reversal is one XOR away.
  typedef enum logic [1:0] {D_UP = 2'b00, D_DOWN = 2'b01, D_LEFT = 2'b10, D_RIGHT = 2'b11} dir_t;

  state_t           r_state;
  dir_t             r_dir_app;
  dir_t             r_dir_pend;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_len;
  logic             r_apple_eaten;
  logic             r_game_over;
  logic [5:0]       r_nx;
  logic [4:0]       r_ny;
  logic             r_grow;
  logic             r_eat;
  logic [5:0]       r_seg_x [MAX_LEN];
  logic [4:0]       r_seg_y [MAX_LEN];

  logic       w_start;
  dir_t       w_rev;
  logic       w_key_vld;
  dir_t       w_key_dir;
  logic [5:0] w_nx;
  logic [4:0] w_ny;
  logic       w_eat;
  logic       w_grow;
  logic       w_wall_hit;
  logic       w_body_hit;
  logic [4:0] w_lim;
  logic [5:0] w_cx;
  logic [5:0] w_cy;

  assign w_start = Start && (r_state == S_IDLE || r_state == S_DEAD);
  assign w_rev   = dir_t'({r_dir_app[1], ~r_dir_app[0]});

  always_comb begin
    w_key_vld = 1'b0;
    w_key_dir = D_RIGHT;
    if (Key_right && w_rev != D_RIGHT) begin w_key_vld = 1'b1; w_key_dir = D_RIGHT; end
    if (Key_left  && w_rev != D_LEFT)  begin w_key_vld = 1'b1; w_key_dir = D_LEFT;  end
    if (Key_down  && w_rev != D_DOWN)  begin w_key_vld = 1'b1; w_key_dir = D_DOWN;  end
    if (Key_up    && w_rev != D_UP)    begin w_key_vld = 1'b1; w_key_dir = D_UP;    end
  end

  always_comb begin
    w_nx = r_seg_x[0];
    w_ny = r_seg_y[0];
    case (r_dir_pend)
      D_UP:    w_ny = (WRAP && r_seg_y[0] == 5'd0)  ? 5'd29 : r_seg_y[0] - 5'd1;
      D_DOWN:  w_ny = (WRAP && r_seg_y[0] == 5'd29) ? 5'd0  : r_seg_y[0] + 5'd1;
      D_LEFT:  w_nx = (WRAP && r_seg_x[0] == 6'd0)  ? 6'd39 : r_seg_x[0] - 6'd1;
      default: w_nx = (WRAP && r_seg_x[0] == 6'd39) ? 6'd0  : r_seg_x[0] + 6'd1;
    endcase
  end

  // The tail vacates its cell on a non-growing step, so it is excluded from the self-hit test.
  always_comb begin
    w_eat      = (w_nx == Apple_x) && (w_ny == Apple_y);
    w_grow     = w_eat && (r_len < 5'(MAX_LEN));
    w_wall_hit = !WRAP && (w_nx == 6'd0 || w_nx == 6'd39 || w_ny == 5'd0 || w_ny == 5'd29);
    w_lim      = w_grow ? r_len : r_len - 5'd1;
    w_body_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(w_lim) && r_seg_x[i] == w_nx && r_seg_y[i] == w_ny) w_body_hit = 1'b1;
    end
  end

  assign w_cx = Pixel_x[9:4];
  assign w_cy = Pixel_y[9:4];

  always_comb begin
    Object = OBJ_NONE;
    if (Pixel_x < 10'd640 && Pixel_y < 10'd480) begin
      for (int i = 1; i < MAX_LEN; i++) begin
        if (i < int'(r_len) && r_seg_x[i] == w_cx && {1'b0, r_seg_y[i]} == w_cy) Object = OBJ_BODY;
      end
      if (r_seg_x[0] == w_cx && {1'b0, r_seg_y[0]} == w_cy) Object = OBJ_HEAD;
      if (!WRAP && (w_cx == 6'd0 || w_cx == 6'd39 || w_cy == 6'd0 || w_cy == 6'd29)) Object = OBJ_WALL;
    end
  end

  always_ff @(posedge Clk_25mhz) begin
    if (Rst || w_start) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= 6'(20 - i);
        r_seg_y[i] <= 5'd15;
      end
    end else if (r_state == S_MOVE) begin
      for (int i = MAX_LEN - 1; i > 0; i--) begin
        r_seg_x[i] <= r_seg_x[i-1];
        r_seg_y[i] <= r_seg_y[i-1];
      end
      r_seg_x[0] <= r_nx;
      r_seg_y[0] <= r_ny;
    end
  end

  always_ff @(posedge Clk_25mhz) begin
    if (Rst) begin
      r_state       <= S_IDLE;
      r_dir_app     <= D_RIGHT;
      r_dir_pend    <= D_RIGHT;
      r_cnt         <= '0;
      r_len         <= 5'(INIT_LEN);
      r_apple_eaten <= 1'b0;
      r_game_over   <= 1'b0;
      r_nx          <= '0;
      r_ny          <= '0;
      r_grow        <= 1'b0;
      r_eat         <= 1'b0;
    end else begin
      r_apple_eaten <= 1'b0;
      if (w_key_vld && r_state != S_DEAD) r_dir_pend <= w_key_dir;
      case (r_state)
        S_IDLE, S_DEAD: begin
          if (Start) begin
            r_state     <= S_RUN;
            r_dir_app   <= D_RIGHT;
            r_dir_pend  <= D_RIGHT;
            r_cnt       <= '0;
            r_len       <= 5'(INIT_LEN);
            r_game_over <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_cnt == CNT_W'(STEP_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          r_dir_app <= r_dir_pend;
          if (w_wall_hit || w_body_hit) begin
            r_state     <= S_DEAD;
            r_game_over <= 1'b1;
          end else begin
            r_state <= S_MOVE;
            r_nx    <= w_nx;
            r_ny    <= w_ny;
            r_grow  <= w_grow;
            r_eat   <= w_eat;
          end
        end
        S_MOVE: begin
          r_state       <= S_RUN;
          r_apple_eaten <= r_eat;
          if (r_grow) r_len <= r_len + 5'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Apple_eaten = r_apple_eaten;
  assign Game_over   = r_game_over;
  assign Snake_len   = r_len;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Scoreboard bench for snake_step_ctrl: stimulus queues hand-computed expectations, a negedge monitor compares.
module tb_snake_step_ctrl;

`ifdef SNAKE_WALL_WRAP_EN
  localparam int EXP_WALL = 0;
`else
  localparam int EXP_WALL = 3;
`endif

  localparam int K_OBJ = 0, K_LEN = 1, K_GO = 2, K_EAT = 3;

  logic       clk;
  logic       Rst, Start, Key_up, Key_down, Key_left, Key_right;
  logic [5:0] Apple_x;
  logic [4:0] Apple_y;
  logic [9:0] Pixel_x, Pixel_y;
  logic [1:0] Object;
  logic       Apple_eaten, Game_over;
  logic [4:0] Snake_len;

  snake_step_ctrl #(.STEP_CYCLES(8), .MAX_LEN(16), .INIT_LEN(3)) dut (
    .Clk_25mhz(clk), .Rst(Rst), .Start(Start),
    .Key_up(Key_up), .Key_down(Key_down), .Key_left(Key_left), .Key_right(Key_right),
    .Apple_x(Apple_x), .Apple_y(Apple_y), .Pixel_x(Pixel_x), .Pixel_y(Pixel_y),
    .Object(Object), .Apple_eaten(Apple_eaten), .Game_over(Game_over), .Snake_len(Snake_len)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    string name;
    int    kind;
    int    exp;
  } exp_t;

  exp_t sb_q[$];
  logic chk_req;
  int   n_cmp, n_bad, eat_cnt, exp_eat, cyc, c1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts Apple_eaten cycles and compares whenever the stimulus side raises a request.
  always @(negedge clk) begin
    int act;
    exp_t e;
    if (Apple_eaten) eat_cnt++;
    if (chk_req) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard: request with no expectation queued");
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          K_OBJ:   act = int'(Object);
          K_LEN:   act = int'(Snake_len);
          K_GO:    act = int'(Game_over);
          default: act = eat_cnt;
        endcase
        if (act != e.exp) begin
          n_bad++;
          $display("FAIL %s: got %0d, expected %0d (t=%0t)", e.name, act, e.exp, $time);
        end
      end
    end
  end

  task automatic chk(input string name, input int kind, input int exp, input int px, input int py);
    @(posedge clk); #1;
    Pixel_x = 10'(px);
    Pixel_y = 10'(py);
    sb_q.push_back('{name, kind, exp});
    chk_req = 1'b1;
    @(negedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic obj(input string name, input int exp, input int px, input int py);
    chk(name, K_OBJ, exp, px, py);
  endtask

  task automatic key(input int k);
    @(posedge clk); #1;
    Key_up = (k == 0); Key_down = (k == 1); Key_left = (k == 2); Key_right = (k == 3);
    @(posedge clk); #1;
    {Key_up, Key_down, Key_left, Key_right} = 4'b0000;
  endtask

  task automatic start_game();
    @(posedge clk); #1; Start = 1'b1;
    @(posedge clk); #1; Start = 1'b0;
    c1 = cyc;
  endtask

  task automatic reset_dut();
    Rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 Rst = 1'b0;
  endtask

  // Each step is 8 RUN + CHECK + MOVE cycles; step k's update lands at cycle c1 + 10*k.
  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  task automatic step_to(input int k);
    wait_cyc(c1 + 10 * k);
  endtask

  task automatic set_apple(input int x, input int y);
    Apple_x = 6'(x);
    Apple_y = 5'(y);
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; chk_req = 1'b0;
    {Key_up, Key_down, Key_left, Key_right} = 4'b0000;
    Pixel_x = '0; Pixel_y = '0;
    n_cmp = 0; n_bad = 0; eat_cnt = 0; exp_eat = 0; cyc = 0; c1 = 0;
    set_apple(1, 1);
    reset_dut();

    // Reset state and pixel query boundaries.
    obj("rst_head", 1, 320, 240);
    obj("rst_body", 2, 300, 240);
    obj("rst_beyond_len", 0, 272, 240);
    obj("rst_wall_00", EXP_WALL, 0, 0);
    obj("rst_wall_corner", EXP_WALL, 639, 479);
    obj("rst_x_off", 0, 700, 10);
    obj("rst_y_off", 0, 100, 480);
    chk("rst_len", K_LEN, 3, 0, 0);
    chk("rst_go", K_GO, 0, 0, 0);

    // Plain step, then apple capture.
    start_game();
    step_to(1);
    set_apple(22, 15);
    obj("s1_head", 1, 336, 240);
    obj("s1_neck", 2, 320, 240);
    obj("s1_old_tail", 0, 288, 240);
    chk("s1_len", K_LEN, 3, 0, 0);
    chk("s1_eat", K_EAT, exp_eat, 0, 0);

    step_to(2);
    exp_eat++;
    obj("s2_head", 1, 352, 240);
    obj("s2_tail_kept", 2, 304, 240);
    chk("s2_len", K_LEN, 4, 0, 0);
    chk("s2_eat", K_EAT, exp_eat, 0, 0);
    set_apple(1, 1);
    key(2);

    // Reversal ignored, then a turn.
    step_to(3);
    obj("s3_head_rev_ignored", 1, 368, 240);
    key(0);
    step_to(4);
    obj("s4_head_up", 1, 368, 224);
    obj("s4_neck", 2, 368, 240);
    chk("s4_eat_once", K_EAT, exp_eat, 0, 0);
    key(3);

    // Run right along row 14 into the east wall.
    step_to(19);
    obj("s19_head", 1, 608, 224);
    chk("s19_go", K_GO, 0, 0, 0);
    step_to(20);
`ifdef SNAKE_WALL_WRAP_EN
    obj("w20_head_x39", 1, 624, 224);
    chk("w20_go", K_GO, 0, 0, 0);
    step_to(21);
    obj("w21_head_wrapped", 1, 0, 224);
    obj("w21_neck", 2, 624, 224);
    reset_dut();
`else
    chk("s20_go", K_GO, 1, 0, 0);
    obj("s20_head_frozen", 1, 608, 224);
    obj("s20_wall", 3, 624, 224);
    chk("s20_len", K_LEN, 4, 0, 0);
    step_to(22);
    obj("dead_still_frozen", 1, 608, 224);
    chk("dead_go_level", K_GO, 1, 0, 0);
`endif

    // Restart, grow to 5 and turn into the body.
    set_apple(21, 15);
    start_game();
    obj("rs_head", 1, 320, 240);
    obj("rs_old_head_gone", 0, 608, 224);
    chk("rs_go", K_GO, 0, 0, 0);
    chk("rs_len", K_LEN, 3, 0, 0);
    step_to(1);
    exp_eat++;
    set_apple(22, 15);
    chk("g1_len", K_LEN, 4, 0, 0);
    obj("g1_head", 1, 336, 240);
    step_to(2);
    exp_eat++;
    set_apple(1, 1);
    chk("g2_len", K_LEN, 5, 0, 0);
    chk("g2_eat", K_EAT, exp_eat, 0, 0);
    key(0);
    step_to(3);
    obj("g3_head", 1, 352, 224);
    key(2);
    step_to(4);
    obj("g4_head", 1, 336, 224);
    obj("g4_neck", 2, 352, 224);
    key(1);
    step_to(5);
    chk("self_hit_go", K_GO, 1, 0, 0);
    obj("self_hit_head", 1, 336, 224);
    obj("self_hit_body", 2, 336, 240);
    chk("self_hit_len", K_LEN, 5, 0, 0);

    // Reset during MOVE of a capturing step abandons it.
    set_apple(21, 15);
    start_game();
    wait_cyc(c1 + 9);
    Rst = 1'b1;
    @(posedge clk); #1;
    Rst = 1'b0;
    obj("mr_head", 1, 320, 240);
    obj("mr_no_move", 0, 336, 240);
    chk("mr_len", K_LEN, 3, 0, 0);
    chk("mr_go", K_GO, 0, 0, 0);
    chk("mr_no_eat", K_EAT, exp_eat, 0, 0);
    repeat (15) @(posedge clk);
    obj("mr_idle_frozen", 1, 320, 240);

    repeat (2) @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog timeout");
  end

endmodule
